// File: rtl/pcileech_tx_arbiter.sv
// pcileech_tx_arbiter: round-robin scheduler sharing the FT601 TX FIFO write
// port between four packet sources. Each packet goes out as a header word
// (source ID + length) followed by its data words. A source that stalls for
// too long has the rest of its packet padded and flagged.
module pcileech_tx_arbiter #(
    parameter int          TIMEOUT_CYC = 1024,
    parameter logic [31:0] PAD_WORD    = 32'hFFFFFFFF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   src_req,
    input  logic [63:0]  src_len,
    input  logic [127:0] src_data,
    input  logic [3:0]   src_valid,
    output logic [3:0]   src_ready,
    output logic [3:0]   src_grant,
    output logic [31:0]  fifo_tx_data,
    output logic         fifo_tx_wr,
    input  logic         fifo_tx_full,
    output logic         stat_timeout,
    output logic [1:0]   stat_timeout_src
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_PAD,
        S_DONE
    } state_t;

    state_t         state_reg, state_next;
    logic [1:0]     ptr_reg;
    logic [1:0]     gsrc_reg;
    logic [15:0]    wcnt_reg;
    logic [TW-1:0]  tcnt_reg;

    logic           req_any;
    logic [1:0]     req_sel;
    logic [15:0]    sel_len;
    logic [31:0]    gnt_data;
    logic           gnt_valid;
    logic           do_hdr, do_data, do_pad, do_timeout;

    // Pick the first requester at or after the pointer (mod 4); the
    // descending scan lets the smallest offset win.
    always_comb begin
        req_any = 1'b0;
        req_sel = ptr_reg;
        for (int k = 3; k >= 0; k--) begin
            if (src_req[ptr_reg + 2'(k)]) begin
                req_any = 1'b1;
                req_sel = ptr_reg + 2'(k);
            end
        end
    end

    assign sel_len   = src_len[{req_sel, 4'd0} +: 16];
    assign gnt_data  = src_data[{gsrc_reg, 5'd0} +: 32];
    assign gnt_valid = src_valid[gsrc_reg];

    // Next-state and per-cycle write decisions; src_ready is only ever
    // raised for the granted source while in DATA.
    always_comb begin
        state_next = state_reg;
        src_ready  = 4'b0000;
        do_hdr     = 1'b0;
        do_data    = 1'b0;
        do_pad     = 1'b0;
        do_timeout = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (req_any) state_next = S_HDR;
            end
            S_HDR: begin
                if (!fifo_tx_full) begin
                    do_hdr     = 1'b1;
                    state_next = (wcnt_reg == 16'd0) ? S_DONE : S_DATA;
                end
            end
            S_DATA: begin
                src_ready[gsrc_reg] = !fifo_tx_full;
                if (gnt_valid && !fifo_tx_full) begin
                    do_data = 1'b1;
                    if (wcnt_reg <= 16'd1) state_next = S_DONE;
                end else if (tcnt_reg == TW'(TIMEOUT_CYC - 1)) begin
                    // This idle cycle is the TIMEOUT_CYC-th in a row.
                    do_timeout = 1'b1;
                    state_next = S_PAD;
                end
            end
            S_PAD: begin
                if (wcnt_reg == 16'd0) begin
                    state_next = S_DONE;
                end else if (!fifo_tx_full) begin
                    do_pad = 1'b1;
                    if (wcnt_reg == 16'd1) state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    // Grant bookkeeping, counters, FIFO write port and timeout status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg          <= 2'd0;
            gsrc_reg         <= 2'd0;
            wcnt_reg         <= 16'd0;
            tcnt_reg         <= '0;
            src_grant        <= 4'b0000;
            fifo_tx_data     <= 32'd0;
            fifo_tx_wr       <= 1'b0;
            stat_timeout     <= 1'b0;
            stat_timeout_src <= 2'd0;
        end else begin
            fifo_tx_wr   <= do_hdr | do_data | do_pad;
            stat_timeout <= do_timeout;

            if (state_reg == S_IDLE && req_any) begin
                gsrc_reg  <= req_sel;
                wcnt_reg  <= sel_len;
                src_grant <= 4'b0001 << req_sel;
            end

            // Grant covers HDR through the final DATA/PAD word only.
            if (state_reg != S_DONE && state_next == S_DONE) src_grant <= 4'b0000;

            if (state_reg == S_DONE) ptr_reg <= gsrc_reg + 2'd1;

            if (do_hdr) fifo_tx_data <= {4'hE, gsrc_reg, 10'd0, wcnt_reg};
            else if (do_data) fifo_tx_data <= gnt_data;
            else if (do_pad) fifo_tx_data <= PAD_WORD;

            if ((do_data || do_pad) && wcnt_reg != 16'd0) wcnt_reg <= wcnt_reg - 16'd1;

            // Any non-accepting DATA cycle counts, FIFO-full stalls included.
            if (do_hdr || do_data) tcnt_reg <= '0;
            else if (state_reg == S_DATA && tcnt_reg != TW'(TIMEOUT_CYC)) tcnt_reg <= tcnt_reg + 1'b1;

            if (do_timeout) stat_timeout_src <= gsrc_reg;
        end
    end

endmodule

// File: tb/tb_pcileech_tx_arbiter.sv
// Bench for pcileech_tx_arbiter: directed scenarios plus a randomized run,
// checked against a packet-level model of the expected FIFO word stream.
module tb_pcileech_tx_arbiter;

    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   src_req;
    logic [63:0]  src_len;
    logic [127:0] src_data;
    logic [3:0]   src_valid;
    logic [3:0]   src_ready;
    logic [3:0]   src_grant;
    logic [31:0]  fifo_tx_data;
    logic         fifo_tx_wr;
    logic         fifo_tx_full;
    logic         stat_timeout;
    logic [1:0]   stat_timeout_src;

    pcileech_tx_arbiter #(.TIMEOUT_CYC(TO), .PAD_WORD(32'hFFFFFFFF)) dut (
        .clk(clk), .rst(rst),
        .src_req(src_req), .src_len(src_len), .src_data(src_data), .src_valid(src_valid),
        .src_ready(src_ready), .src_grant(src_grant),
        .fifo_tx_data(fifo_tx_data), .fifo_tx_wr(fifo_tx_wr), .fifo_tx_full(fifo_tx_full),
        .stat_timeout(stat_timeout), .stat_timeout_src(stat_timeout_src)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected stream and timeout sources, built per phase.
    logic [31:0] exp_q[$];
    int          exp_to_q[$];
    int          mp;

    // Source-side packet queues and current packet state.
    int   q_len[4][$];
    int   q_give[4][$];
    int   cur_len[4], cur_give[4], cur_ser[4], sent[4], ser[4];
    bit   active[4], acc[4];
    logic [3:0] prev_grant;
    bit   prev_full;
    int   cyc, last_wr_cyc, phase_acc, hold_at, hold_left, stall_run;
    bit   held, rand_mode;
    int   wcyc[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(int s, int sr, int n);
        return {4'h5, 2'(s), 2'b00, 8'(sr), 16'(n)};
    endfunction

    // Packet-level model: round-robin over sources that still have packets.
    task automatic build_model();
        int ql[4][$];
        int qg[4][$];
        int ms[4];
        int pick, len, give;
        for (int i = 0; i < 4; i++) begin
            ql[i] = q_len[i];
            qg[i] = q_give[i];
            ms[i] = ser[i];
        end
        while (1) begin
            pick = -1;
            for (int k = 0; k < 4; k++)
                if (pick < 0 && ql[(mp + k) % 4].size() > 0) pick = (mp + k) % 4;
            if (pick < 0) break;
            len  = ql[pick].pop_front();
            give = qg[pick].pop_front();
            exp_q.push_back({4'hE, 2'(pick), 10'd0, 16'(len)});
            for (int n = 0; n < len; n++)
                exp_q.push_back(n < give ? word_of(pick, ms[pick], n) : 32'hFFFFFFFF);
            if (give < len) exp_to_q.push_back(pick);
            ms[pick]++;
            mp = (pick + 1) % 4;
        end
    endtask

    task automatic add_pkt(int s, int len, int give);
        q_len[s].push_back(len);
        q_give[s].push_back(give);
    endtask

    // One clock: observe outputs after the edge, update sources, drive inputs,
    // then sample src_ready at the falling edge.
    task automatic step();
        bit sf, si;
        int e;
        @(posedge clk);
        #1;
        cyc++;
        if (prev_full) chk("no_write_after_full", {31'd0, fifo_tx_wr}, 32'd0);
        if (fifo_tx_wr === 1'b1) begin
            wcyc.push_back(cyc);
            $display("write cyc=%0d data=%08h", cyc, fifo_tx_data);
            if (exp_q.size() == 0) chk("unexpected_write", {31'd0, fifo_tx_wr}, 32'd0);
            else chk("fifo_word", fifo_tx_data, exp_q.pop_front());
            last_wr_cyc = cyc;
        end
        if (stat_timeout === 1'b1) begin
            e = (exp_to_q.size() > 0) ? exp_to_q.pop_front() : -1;
            chk("timeout_src", {30'd0, stat_timeout_src}, e);
            chk("timeout_gap", cyc - last_wr_cyc, TO);
        end
        for (int i = 0; i < 4; i++) if (acc[i]) begin sent[i]++; phase_acc++; end
        for (int i = 0; i < 4; i++) begin
            if (!active[i] && q_len[i].size() > 0) begin
                cur_len[i]  = q_len[i].pop_front();
                cur_give[i] = q_give[i].pop_front();
                cur_ser[i]  = ser[i];
                ser[i]++;
                sent[i]   = 0;
                active[i] = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) if (prev_grant[i] && !src_grant[i]) active[i] = 1'b0;
        prev_grant = src_grant;

        if (hold_at >= 0 && !held && phase_acc >= hold_at) begin held = 1'b1; hold_left = 5; end
        sf = 1'b0;
        si = 1'b0;
        if (hold_left > 0) begin
            sf = 1'b1;
            hold_left--;
        end else if (rand_mode && stall_run < 3 && $urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 1) sf = 1'b1;
            else si = 1'b1;
        end
        stall_run    = (sf || si) ? stall_run + 1 : 0;
        fifo_tx_full = sf;
        prev_full    = sf;
        for (int i = 0; i < 4; i++) begin
            src_req[i] = active[i];
            src_len[16*i +: 16] = active[i] ? 16'(cur_len[i]) : 16'($urandom);
            if (active[i] && sent[i] < cur_give[i]) begin
                src_valid[i] = !si;
                src_data[32*i +: 32] = word_of(i, cur_ser[i], sent[i]);
            end else if (active[i]) begin
                src_valid[i] = 1'b0;
                src_data[32*i +: 32] = 32'hBAD00000 | 32'(i);
            end else begin
                src_valid[i] = 1'($urandom_range(0, 1));
                src_data[32*i +: 32] = 32'hBAD00000 | 32'(i);
            end
        end
        @(negedge clk);
        chk("ready_only_granted", {28'd0, src_ready & ~src_grant}, 32'd0);
        if (fifo_tx_full) chk("ready_low_when_full", {28'd0, src_ready}, 32'd0);
        for (int i = 0; i < 4; i++) acc[i] = src_valid[i] & src_ready[i];
    endtask

    function automatic bit busy();
        bit b = (exp_q.size() > 0);
        for (int i = 0; i < 4; i++) if (active[i] || q_len[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic run_phase(int budget);
        int n = 0;
        build_model();
        phase_acc = 0;
        held = 1'b0;
        wcyc.delete();
        while (busy() && n < budget) begin
            step();
            n++;
        end
        chk("phase_cycle_budget", {31'd0, n < budget}, 32'd1);
        repeat (4) step();
        chk("timeouts_outstanding", exp_to_q.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        src_req = '0; src_len = '0; src_data = '0; src_valid = '0; fifo_tx_full = 1'b0;
        mp = 0; cyc = 0; last_wr_cyc = 0; hold_at = -1; hold_left = 0; stall_run = 0;
        held = 1'b0; rand_mode = 1'b0; prev_grant = '0; prev_full = 1'b0;
        for (int i = 0; i < 4; i++) begin active[i] = 0; acc[i] = 0; ser[i] = 0; sent[i] = 0; end
        #3;
        chk("rst_grant", {28'd0, src_grant}, 32'd0);
        chk("rst_ready", {28'd0, src_ready}, 32'd0);
        chk("rst_wr", {31'd0, fifo_tx_wr}, 32'd0);
        chk("rst_data", fifo_tx_data, 32'd0);
        chk("rst_timeout", {31'd0, stat_timeout}, 32'd0);
        chk("rst_timeout_src", {30'd0, stat_timeout_src}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Round robin from reset: order 0,1,2,3,0.
        for (int i = 0; i < 4; i++) add_pkt(i, 1, 1);
        add_pkt(0, 1, 1);
        run_phase(300);

        // Single packet from source 1, written on consecutive cycles.
        add_pkt(1, 3, 3);
        run_phase(200);
        chk("single_write_count", wcyc.size(), 32'd4);
        if (wcyc.size() == 4) chk("single_consecutive", wcyc[3] - wcyc[0], 32'd3);

        // Timeout: source 2 supplies one of four words.
        add_pkt(2, 4, 1);
        run_phase(200);

        // Zero length from source 3, then source 0.
        add_pkt(3, 0, 0);
        add_pkt(0, 1, 1);
        run_phase(200);

        // Backpressure mid-packet, words must resume in order.
        hold_at = 2;
        add_pkt(1, 6, 6);
        run_phase(200);

        // Full-stall cycles count toward the timeout.
        hold_at = 1;
        add_pkt(1, 3, 1);
        run_phase(200);
        hold_at = -1;

        // Randomized traffic with stalls, backpressure and some timeouts.
        rand_mode = 1'b1;
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 4; i++) begin
                int len, give;
                len  = $urandom_range(0, 6);
                give = len;
                if (len > 0 && $urandom_range(0, 4) == 0) give = $urandom_range(0, len - 1);
                add_pkt(i, len, give);
            end
        end
        run_phase(5000);
        rand_mode = 1'b0;

        // Asynchronous reset mid-DATA with pointer at 2, then fresh arbitration.
        add_pkt(1, 2, 2);
        add_pkt(2, 1, 0);
        run_phase(300);
        add_pkt(2, 8, 8);
        build_model();
        for (int n = 0; n < 60 && sent[2] < 3; n++) step();
        chk("reached_mid_data", {31'd0, sent[2] >= 3}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_grant", {28'd0, src_grant}, 32'd0);
        chk("arst_ready", {28'd0, src_ready}, 32'd0);
        chk("arst_wr", {31'd0, fifo_tx_wr}, 32'd0);
        chk("arst_data", fifo_tx_data, 32'd0);
        chk("arst_timeout", {31'd0, stat_timeout}, 32'd0);
        chk("arst_timeout_src", {30'd0, stat_timeout_src}, 32'd0);
        exp_q.delete();
        exp_to_q.delete();
        for (int i = 0; i < 4; i++) begin
            active[i] = 0; acc[i] = 0;
            q_len[i].delete(); q_give[i].delete();
        end
        mp = 0; prev_grant = '0; prev_full = 1'b0; hold_left = 0;
        src_req = '0; src_valid = '0; fifo_tx_full = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        add_pkt(1, 2, 2);
        add_pkt(3, 2, 2);
        run_phase(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
